// File: rtl/burst_wr_pkg.sv
// Shared types and helpers for the burst write controller.
package burst_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_DATA,
    BURST,
    DONE,
    WAIT_RELEASE
  } state_t;

  localparam int unsigned CTRL_ABORT_BIT = 0;

  // Legal burst length: min of remaining words, max burst and words left
  // before the next boundary. addr is a byte address.
  function automatic int unsigned burst_len(
    input logic [63:0] rem,
    input logic [63:0] addr,
    input int unsigned max_burst,
    input int unsigned boundary,
    input int unsigned bytes
  );
    logic [63:0] offs;
    logic [63:0] room;
    offs = addr & (64'(boundary) - 64'd1);
    room = (64'(boundary) - offs) / 64'(bytes);
    if (64'(max_burst) < room) room = 64'(max_burst);
    if (rem < room) room = rem;
    return room[31:0];
  endfunction

endpackage

// File: rtl/burst_wr_ctrl_if.sv
// Avalon-MM burst write bus between the controller and the memory bridge.
interface burst_wr_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BC_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic [BC_W-1:0]   burstcount;
  logic              waitrequest;

  modport master (
    output address, writedata, write, burstcount,
    input  waitrequest
  );

  modport slave (
    input  address, writedata, write, burstcount,
    output waitrequest
  );
endinterface

// File: rtl/burst_len_calc.sv
// Registered burst length for the next burst from remaining words and address.
module burst_len_calc
  import burst_wr_pkg::*;
#(
  parameter  int unsigned ADDR_W         = 32,
  parameter  int unsigned DATA_W         = 32,
  parameter  int unsigned MAX_BURST      = 8,
  parameter  int unsigned BOUNDARY_BYTES = 4096,
  localparam int unsigned BC_W           = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] rem_words,
  input  logic [ADDR_W-1:0] cur_addr,
  output logic [BC_W-1:0]   blen
);

  // Capture the min-of-three length when the controller asks for it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blen <= '0;
    end else if (load) begin
      blen <= BC_W'(burst_len(64'(rem_words), 64'(cur_addr), MAX_BURST,
                              BOUNDARY_BYTES, DATA_W / 8));
    end
  end

endmodule

// File: rtl/burst_wr_ctrl.sv
// Drains one packet from a show-ahead FIFO into memory as legal Avalon bursts.
module burst_wr_ctrl
  import burst_wr_pkg::*;
#(
  parameter  int unsigned DATA_W         = 32,
  parameter  int unsigned ADDR_W         = 32,
  parameter  int unsigned MAX_BURST      = 8,
  parameter  int unsigned BOUNDARY_BYTES = 4096,
  parameter  int unsigned USEDW_W        = 9,
  localparam int unsigned BC_W           = $clog2(MAX_BURST) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_ctrl,
  input  logic [31:0]        control,
  input  logic [ADDR_W-1:0]  pkt_begin,
  input  logic [ADDR_W-1:0]  pkt_end,
  input  logic [ADDR_W-1:0]  write_address,
  input  logic [DATA_W-1:0]  fifo_out,
  input  logic               empty,
  input  logic [USEDW_W-1:0] usedw,
  output logic               rd_from_fifo,
  output logic               wr_ctrl_rdy,
  output logic               done,
  output logic [ADDR_W-1:0]  words_written,
  burst_wr_ctrl_if.master    avm
);

  localparam int unsigned BYTES = DATA_W / 8;

  state_t state, state_nx;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rem_words;
  logic [ADDR_W-1:0] address_q;
  logic [BC_W-1:0]   burstcount_q;
  logic [BC_W-1:0]   beat_cnt;
  logic [BC_W-1:0]   blen;
  logic              write_q;

  logic              accept;
  logic              calc;
  logic              start;
  logic              last;
  logic              beat;
  logic [ADDR_W-1:0] len_bytes;
  logic [ADDR_W:0]   len_round;
  logic              unused_ctrl;

  // Only the abort bit of control is meaningful.
  assign unused_ctrl = ^control;

  // Packet length in bytes, clamped at zero, rounded up to whole words.
  always_comb begin
    len_bytes = '0;
    if (pkt_end > pkt_begin) len_bytes = pkt_end - pkt_begin;
    len_round = {1'b0, len_bytes} + (ADDR_W + 1)'(BYTES - 1);
  end

  assign beat         = write_q & ~avm.waitrequest;
  assign rd_from_fifo = beat;

  assign avm.address    = address_q;
  assign avm.burstcount = burstcount_q;
  assign avm.write      = write_q;
  assign avm.writedata  = fifo_out;

  burst_len_calc #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_BURST     (MAX_BURST),
    .BOUNDARY_BYTES(BOUNDARY_BYTES)
  ) u_len_calc (
    .clk      (clk),
    .reset    (reset),
    .load     (calc),
    .rem_words(rem_words),
    .cur_addr (cur_addr),
    .blen     (blen)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    calc        = 1'b0;
    start       = 1'b0;
    last        = 1'b0;
    wr_ctrl_rdy = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        wr_ctrl_rdy = 1'b1;
        if (wr_ctrl) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (rem_words == '0 || control[CTRL_ABORT_BIT]) begin
          state_nx = DONE;
        end else begin
          calc     = 1'b1;
          state_nx = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (!empty && 32'(usedw) >= 32'(blen)) begin
          start    = 1'b1;
          state_nx = BURST;
        end
      end
      BURST: begin
        if (beat && beat_cnt == blen - 1'b1) begin
          last     = 1'b1;
          state_nx = CALC;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!wr_ctrl) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transfer bookkeeping and Avalon command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr      <= '0;
      rem_words     <= '0;
      words_written <= '0;
      address_q     <= '0;
      burstcount_q  <= '0;
      beat_cnt      <= '0;
      write_q       <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr      <= write_address;
        rem_words     <= ADDR_W'(len_round / (ADDR_W + 1)'(BYTES));
        words_written <= '0;
      end
      if (start) begin
        address_q    <= cur_addr;
        burstcount_q <= blen;
        beat_cnt     <= '0;
        write_q      <= 1'b1;
      end
      if (beat) begin
        beat_cnt      <= beat_cnt + 1'b1;
        words_written <= words_written + 1'b1;
      end
      if (last) begin
        write_q   <= 1'b0;
        cur_addr  <= cur_addr + ADDR_W'(blen) * ADDR_W'(BYTES);
        rem_words <= rem_words - ADDR_W'(blen);
      end
    end
  end

endmodule
